// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver and its future transmitter.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider: one-cycle tick every DIV clocks; clr restarts the phase.
module uart_baud_tick #(
    parameter int DIV = 325
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (clr || r_cnt == LAST)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    assign tick = (r_cnt == LAST) && !clr;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 3-sample majority vote per bit, false-start rejection,
// configurable frame format, valid/ready output with parity/framing/overrun reporting.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int BAUD       = 19200,
    parameter int CLK_RATE   = 100000000,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic                 busy,
    output logic                 valid,
    input  logic                 ready,
    output logic [DATA_BITS-1:0] data,
    output logic                 perr,
    output logic                 ferr,
    output logic                 overrun
);
    localparam int TICK_DIV = CLK_RATE / (BAUD * OVERSAMPLE);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [SW-1:0] S_M1   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_M    = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_DEC  = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_DATA = BW'(DATA_BITS);
    localparam logic [BW-1:0] B_STOP = BW'(STOP_BITS - 1);
    localparam logic          ODD    = (PARITY == PARITY_ODD);

    if (TICK_DIV < 1) begin : g_bad_div
        $error("uart_rx_os: CLK_RATE too low for BAUD*OVERSAMPLE");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY < 0 || PARITY > 2 || OVERSAMPLE < 8 ||
        (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_cfg
        $error("uart_rx_os: illegal frame or oversampling configuration");
    end

    logic [1:0]           r_sync;
    rx_state_t            r_state, w_next;
    logic [SW-1:0]        r_s;
    logic [BW-1:0]        r_bits;
    logic [1:0]           r_smp;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr_acc, r_ferr_acc;
    logic                 r_valid, r_perr, r_ferr, r_overrun;
    logic [DATA_BITS-1:0] r_data;
    logic                 w_rxs, w_tick, w_clr, w_dec, w_last, w_maj, w_deliver;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= 2'b11;
        else        r_sync <= {r_sync[0], rx};
    end
    assign w_rxs = r_sync[1];

    uart_baud_tick #(.DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .tick  (w_tick)
    );

    assign w_dec  = w_tick && (r_s == S_DEC);
    assign w_last = w_tick && (r_s == S_LAST);
    assign w_maj  = maj3(r_smp[0], r_smp[1], w_rxs);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_clr     = 1'b0;
        w_deliver = 1'b0;
        case (r_state)
            IDLE:  if (!w_rxs) begin
                       w_next = START;
                       w_clr  = 1'b1;
                   end
            START: if (w_dec && w_maj) w_next = IDLE;
                   else if (w_last)    w_next = DATA;
            DATA:  if (w_last && r_bits == B_DATA)
                       w_next = (PARITY != PARITY_NONE) ? PAR : STOP;
            PAR:   if (w_last) w_next = STOP;
            STOP:  if (w_dec && r_bits == B_STOP) begin
                       w_deliver = 1'b1;
                       w_next    = IDLE;
                   end
            default: w_next = IDLE;
        endcase
    end

    // Bit timing and frame accumulation; r_bits counts data bits, then stop bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s        <= '0;
            r_bits     <= '0;
            r_smp      <= 2'b11;
            r_shift    <= '0;
            r_perr_acc <= 1'b0;
            r_ferr_acc <= 1'b0;
        end else if (w_clr) begin
            r_s        <= '0;
            r_bits     <= '0;
            r_perr_acc <= 1'b0;
            r_ferr_acc <= 1'b0;
        end else if (w_tick) begin
            r_s <= (r_s == S_LAST) ? '0 : r_s + 1'b1;
            if (r_s == S_M1) r_smp[0] <= w_rxs;
            if (r_s == S_M)  r_smp[1] <= w_rxs;
            if (w_dec) begin
                case (r_state)
                    DATA: begin
                        r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
                        r_bits  <= r_bits + 1'b1;
                    end
                    PAR:  r_perr_acc <= (^r_shift) ^ w_maj ^ ODD;
                    STOP: begin
                        r_ferr_acc <= r_ferr_acc | ~w_maj;
                        r_bits     <= r_bits + 1'b1;
                    end
                    default: ;
                endcase
            end
            if (w_last && r_state == DATA && r_bits == B_DATA) r_bits <= '0;
        end
    end

    // A delivery that meets an unconsumed word keeps the old word and flags overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_deliver) begin
                if (!r_valid || ready) begin
                    r_valid <= 1'b1;
                    r_data  <= r_shift;
                    r_perr  <= (PARITY != PARITY_NONE) && r_perr_acc;
                    r_ferr  <= r_ferr_acc | ~w_maj;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign busy    = (r_state != IDLE);
    assign valid   = r_valid;
    assign data    = r_data;
    assign perr    = r_perr;
    assign ferr    = r_ferr;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench: an 8N1 receiver (a) and an 8E2 receiver (b) on a fast tick divider.
module tb_uart_rx_os;
    localparam int BAUD     = 19200;
    localparam int OS       = 16;
    localparam int DIV      = 8;
    localparam int CLK_RATE = BAUD * OS * DIV;
    localparam int BIT      = OS * DIV;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       f;
    } frm_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_a = 1'b1, rx_b = 1'b1;
    logic       ready_a = 1'b1, ready_b = 1'b1;
    logic       busy_a, valid_a, perr_a, ferr_a, overrun_a;
    logic       busy_b, valid_b, perr_b, ferr_b, overrun_b;
    logic [7:0] data_a, data_b;

    frm_t exp_a[$], exp_b[$], obs_a[$], obs_b[$];
    int   checks = 0, failures = 0;
    int   vcyc_a = 0, ovr_a = 0;
    logic prev_valid_a = 1'b0, prev_busy_a = 1'b0;
    logic rise_busy_prev = 1'b0, rise_busy_now = 1'b1;

    always #5 clk = ~clk;

    uart_rx_os #(.CLK_RATE(CLK_RATE), .BAUD(BAUD), .OVERSAMPLE(OS)) dut_a (
        .clk(clk), .rst_n(rst_n), .rx(rx_a), .busy(busy_a), .valid(valid_a),
        .ready(ready_a), .data(data_a), .perr(perr_a), .ferr(ferr_a), .overrun(overrun_a)
    );

    uart_rx_os #(.PARITY(2), .STOP_BITS(2), .CLK_RATE(CLK_RATE), .BAUD(BAUD), .OVERSAMPLE(OS)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx(rx_b), .busy(busy_b), .valid(valid_b),
        .ready(ready_b), .data(data_b), .perr(perr_b), .ferr(ferr_b), .overrun(overrun_b)
    );

    always @(negedge clk) begin
        if (valid_a && ready_a) obs_a.push_back({data_a, perr_a, ferr_a});
        if (valid_b && ready_b) obs_b.push_back({data_b, perr_b, ferr_b});
        if (valid_a) vcyc_a <= vcyc_a + 1;
        if (overrun_a) ovr_a <= ovr_a + 1;
        if (valid_a && !prev_valid_a) begin
            rise_busy_prev <= prev_busy_a;
            rise_busy_now  <= busy_a;
        end
        prev_valid_a <= valid_a;
        prev_busy_a  <= busy_a;
    end

    task automatic set_line(input int w, input logic v);
        if (w == 0) rx_a = v;
        else        rx_b = v;
    endtask

    task automatic drive_bits(input int w, input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            set_line(w, v[i]);
            repeat (BIT) @(negedge clk);
        end
        set_line(w, 1'b1);
    endtask

    task automatic test_reset;
        repeat (4) @(negedge clk);
        checks++;
        if ({busy_a, valid_a, data_a, perr_a, ferr_a, overrun_a} !== 13'd0) begin
            failures++;
            $display("FAIL reset_a got=%b want=0", {busy_a, valid_a, data_a, perr_a, ferr_a, overrun_a});
        end
        checks++;
        if ({busy_b, valid_b, data_b, perr_b, ferr_b, overrun_b} !== 13'd0) begin
            failures++;
            $display("FAIL reset_b got=%b want=0", {busy_b, valid_b, data_b, perr_b, ferr_b, overrun_b});
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic;
        frm_t got, want;
        int   v0;
        v0 = vcyc_a;
        exp_a.push_back({8'hA5, 1'b0, 1'b0});
        rx_a = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy_a !== 1'b0) begin
            failures++; $display("FAIL busy_early got=%b want=0", busy_a);
        end
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b1) begin
            failures++; $display("FAIL busy_rise got=%b want=1", busy_a);
        end
        repeat (BIT - 3) @(negedge clk);
        drive_bits(0, {1'b1, 8'hA5}, 9);
        repeat (BIT) @(negedge clk);
        checks++;
        if (obs_a.size() !== 1) begin
            failures++; $display("FAIL basic_count got=%0d want=1", obs_a.size());
        end else begin
            got = obs_a.pop_front(); want = exp_a.pop_front();
            checks++;
            if (got !== want) begin
                failures++; $display("FAIL basic_frame got=%h want=%h", got, want);
            end
        end
        checks++;
        if (vcyc_a - v0 !== 1) begin
            failures++; $display("FAIL basic_valid_cycles got=%0d want=1", vcyc_a - v0);
        end
        checks++;
        if ({rise_busy_prev, rise_busy_now} !== 2'b10) begin
            failures++; $display("FAIL busy_fall_at_valid got=%b want=10", {rise_busy_prev, rise_busy_now});
        end
    endtask

    task automatic test_parity;
        frm_t got, want;
        for (int k = 0; k < 2; k++) begin
            logic pb;
            pb = (k == 1);
            exp_b.push_back({8'h37, ~pb, 1'b0});
            @(negedge clk);
            drive_bits(1, {2'b11, pb, 8'h37, 1'b0}, 12);
            repeat (BIT) @(negedge clk);
            checks++;
            if (obs_b.size() !== 1) begin
                failures++; $display("FAIL parity_count[%0d] got=%0d want=1", k, obs_b.size());
            end else begin
                got = obs_b.pop_front(); want = exp_b.pop_front();
                checks++;
                if (got !== want) begin
                    failures++; $display("FAIL parity_frame[%0d] got=%h want=%h", k, got, want);
                end
            end
        end
    endtask

    task automatic test_framing;
        frm_t got, want;
        exp_b.push_back({8'h3C, 1'b0, 1'b1});
        @(negedge clk);
        drive_bits(1, {1'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 12);
        repeat (2 * BIT) @(negedge clk);
        checks++;
        if (obs_b.size() !== 1) begin
            failures++; $display("FAIL framing_count got=%0d want=1", obs_b.size());
        end else begin
            got = obs_b.pop_front(); want = exp_b.pop_front();
            checks++;
            if (got !== want) begin
                failures++; $display("FAIL framing_frame got=%h want=%h", got, want);
            end
        end
    endtask

    task automatic test_glitch;
        int v0;
        v0 = vcyc_a;
        @(negedge clk);
        rx_a = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (busy_a !== 1'b1) begin
            failures++; $display("FAIL glitch_busy_rise got=%b want=1", busy_a);
        end
        repeat (3 * DIV - 5) @(negedge clk);
        rx_a = 1'b1;
        for (int k = 0; k < 2 * BIT && busy_a; k++) @(negedge clk);
        checks++;
        if (busy_a !== 1'b0) begin
            failures++; $display("FAIL glitch_busy_fall got=%b want=0", busy_a);
        end
        repeat (BIT) @(negedge clk);
        checks++;
        if (vcyc_a - v0 !== 0 || obs_a.size() !== 0) begin
            failures++; $display("FAIL glitch_no_valid got=%0d cycles want=0", vcyc_a - v0);
        end
    endtask

    task automatic test_overrun;
        frm_t got, want;
        int   o0;
        o0 = ovr_a;
        @(posedge clk); #1 ready_a = 1'b0;
        exp_a.push_back({8'h11, 1'b0, 1'b0});
        @(negedge clk);
        drive_bits(0, {1'b1, 8'h11, 1'b0}, 10);
        checks++;
        if ({valid_a, data_a} !== {1'b1, 8'h11}) begin
            failures++; $display("FAIL overrun_first got=%b/%h want=1/11", valid_a, data_a);
        end
        drive_bits(0, {1'b1, 8'h22, 1'b0}, 10);
        repeat (BIT) @(negedge clk);
        checks++;
        if ({valid_a, data_a} !== {1'b1, 8'h11}) begin
            failures++; $display("FAIL overrun_hold got=%b/%h want=1/11", valid_a, data_a);
        end
        checks++;
        if (ovr_a - o0 !== 1) begin
            failures++; $display("FAIL overrun_pulses got=%0d want=1", ovr_a - o0);
        end
        @(posedge clk); #1 ready_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (valid_a !== 1'b0) begin
            failures++; $display("FAIL overrun_consume got=%b want=0", valid_a);
        end
        checks++;
        if (obs_a.size() !== 1) begin
            failures++; $display("FAIL overrun_count got=%0d want=1", obs_a.size());
        end else begin
            got = obs_a.pop_front(); want = exp_a.pop_front();
            checks++;
            if (got !== want) begin
                failures++; $display("FAIL overrun_frame got=%h want=%h", got, want);
            end
        end
    endtask

    task automatic test_back_to_back;
        frm_t got, want;
        exp_b.push_back({8'h81, 1'b0, 1'b0});
        exp_b.push_back({8'h7E, 1'b0, 1'b0});
        @(negedge clk);
        drive_bits(1, {2'b11, 1'b0, 8'h81, 1'b0}, 12);
        drive_bits(1, {2'b11, 1'b0, 8'h7E, 1'b0}, 12);
        repeat (BIT) @(negedge clk);
        checks++;
        if (obs_b.size() !== 2) begin
            failures++; $display("FAIL b2b_count got=%0d want=2", obs_b.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                got = obs_b.pop_front(); want = exp_b.pop_front();
                checks++;
                if (got !== want) begin
                    failures++; $display("FAIL b2b_frame[%0d] got=%h want=%h", k, got, want);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        frm_t got, want;
        @(negedge clk);
        drive_bits(0, {4'hF, 1'b0}, 5);
        repeat (BIT / 2) @(negedge clk);
        checks++;
        if (busy_a !== 1'b1) begin
            failures++; $display("FAIL midframe_busy got=%b want=1", busy_a);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_a, valid_a, data_a, perr_a, ferr_a, overrun_a} !== 13'd0) begin
            failures++;
            $display("FAIL async_reset got=%b want=0", {busy_a, valid_a, data_a, perr_a, ferr_a, overrun_a});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (BIT) @(negedge clk);
        exp_a.push_back({8'h5A, 1'b0, 1'b0});
        drive_bits(0, {1'b1, 8'h5A, 1'b0}, 10);
        repeat (BIT) @(negedge clk);
        checks++;
        if (obs_a.size() !== 1) begin
            failures++; $display("FAIL post_reset_count got=%0d want=1", obs_a.size());
        end else begin
            got = obs_a.pop_front(); want = exp_a.pop_front();
            checks++;
            if (got !== want) begin
                failures++; $display("FAIL post_reset_frame got=%h want=%h", got, want);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_parity;
        test_framing;
        test_glitch;
        test_overrun;
        test_back_to_back;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
